// File: rtl/pe_inst_sequencer_if.sv
// Bundle between the instruction sequencer, its instruction memory and the datapath.
//   start/numInst/numIter : launch pulse and program shape
//   stall                 : datapath back-pressure, freezes the sequencer pipeline
//   inst_rd_en/addr/data  : synchronous instruction memory read port (data one cycle later)
//   instword/instword_v   : registered word to the field decoder
//   busy/done             : status; done is a one-cycle completion pulse
// The sequencer connects through the slave modport; the driving side uses master.
interface pe_inst_sequencer_if #(
    parameter int unsigned instLen     = 44,
    parameter int unsigned instAddrLen = 8,
    parameter int unsigned iterLen     = 16
);
    logic                   start;
    logic [instAddrLen-1:0] numInst;
    logic [iterLen-1:0]     numIter;
    logic                   stall;
    logic                   inst_rd_en;
    logic [instAddrLen-1:0] inst_rd_addr;
    logic [instLen-1:0]     inst_rd_data;
    logic [instLen-1:0]     instword;
    logic                   instword_v;
    logic                   busy;
    logic                   done;

    modport master (
        output start, numInst, numIter, stall, inst_rd_data,
        input  inst_rd_en, inst_rd_addr, instword, instword_v, busy, done
    );

    modport slave (
        input  start, numInst, numIter, stall, inst_rd_data,
        output inst_rd_en, inst_rd_addr, instword, instword_v, busy, done
    );
endinterface

// File: rtl/pe_inst_sequencer.sv
// Per-PE instruction sequencer: fetches numInst words from the synchronous instruction
// memory numIter times and presents them one per cycle to the field decoder.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pe_inst_sequencer_if.slave (launch, memory read port, decoder output, status)
// Pipeline: fetch (inst_rd_en/addr) -> pend (memory latency) -> instword/instword_v.
// stall freezes every stage while RUN; the memory holds its output while not read,
// so a pending word survives a stall without being re-read.
module pe_inst_sequencer #(
    parameter int unsigned instLen     = 44,
    parameter int unsigned instAddrLen = 8,
    parameter int unsigned iterLen     = 16
) (
    input logic                clk,
    input logic                reset,
    pe_inst_sequencer_if.slave bus
);

    localparam int unsigned CntLen = instAddrLen + iterLen;

    localparam logic [instAddrLen-1:0] AddrOne = {{(instAddrLen-1){1'b0}}, 1'b1};
    localparam logic [iterLen-1:0]     IterOne = {{(iterLen-1){1'b0}}, 1'b1};
    localparam logic [CntLen-1:0]      CntOne  = {{(CntLen-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q;
    logic [instAddrLen-1:0] num_inst_q;
    logic [iterLen-1:0]     num_iter_q;
    logic [instAddrLen-1:0] pc_q;
    logic [iterLen-1:0]     iter_q;
    logic                   fetch_rem_q;
    logic                   pend_q;
    logic [instLen-1:0]     instword_q;
    logic                   instword_v_q;
    logic [CntLen-1:0]      cnt_q;

    logic              run;
    logic              en;
    logic              rd_en;
    logic              last_pc;
    logic              last_iter;
    logic              consume;
    logic              last_word;
    logic [CntLen-1:0] total;

    always_comb begin
        run       = (state_q == StRun);
        en        = !bus.stall;
        rd_en     = run && en && fetch_rem_q;
        last_pc   = (pc_q == num_inst_q - AddrOne);
        last_iter = (iter_q == num_iter_q - IterOne);
        total     = CntLen'(num_inst_q) * CntLen'(num_iter_q);
        consume   = run && instword_v_q && en;
        last_word = consume && (cnt_q == total - CntOne);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            num_inst_q   <= '0;
            num_iter_q   <= '0;
            pc_q         <= '0;
            iter_q       <= '0;
            fetch_rem_q  <= 1'b0;
            pend_q       <= 1'b0;
            instword_q   <= '0;
            instword_v_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        num_inst_q   <= bus.numInst;
                        // A repeat count of zero runs the program once.
                        num_iter_q   <= (bus.numIter == '0) ? IterOne : bus.numIter;
                        pc_q         <= '0;
                        iter_q       <= '0;
                        cnt_q        <= '0;
                        pend_q       <= 1'b0;
                        instword_v_q <= 1'b0;
                        fetch_rem_q  <= (bus.numInst != '0);
                        state_q      <= (bus.numInst == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (en) begin
                        if (rd_en) begin
                            if (last_pc) begin
                                if (!last_iter) begin
                                    // Wrap straight into the next iteration: no bubble.
                                    pc_q   <= '0;
                                    iter_q <= iter_q + IterOne;
                                end else begin
                                    fetch_rem_q <= 1'b0;
                                end
                            end else begin
                                pc_q <= pc_q + AddrOne;
                            end
                        end
                        pend_q       <= rd_en;
                        instword_v_q <= pend_q;
                        if (pend_q) begin
                            instword_q <= bus.inst_rd_data;
                        end
                        if (consume) begin
                            cnt_q <= cnt_q + CntOne;
                        end
                        if (last_word) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    pend_q       <= 1'b0;
                    instword_v_q <= 1'b0;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.inst_rd_en   = rd_en;
    assign bus.inst_rd_addr = pc_q;
    assign bus.instword     = instword_q;
    assign bus.instword_v   = instword_v_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StDone);

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Bench for pe_inst_sequencer: a synchronous memory model feeds the DUT; each run builds
// the expected word and address streams from the program shape and checks them, the
// done timing, stall freezing and the read count cycle by cycle.
module tb_pe_inst_sequencer;

    localparam int unsigned IL = 44;
    localparam int unsigned AL = 8;
    localparam int unsigned TL = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [IL-1:0] mem [256];

    pe_inst_sequencer_if #(.instLen(IL), .instAddrLen(AL), .iterLen(TL)) bus ();

    pe_inst_sequencer #(.instLen(IL), .instAddrLen(AL), .iterLen(TL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the read, held otherwise.
    always @(posedge clk) begin
        if (bus.inst_rd_en) begin
            bus.inst_rd_data <= mem[bus.inst_rd_addr];
        end
    end

    // Launches one program and follows it to done (or to a reset at cycle reset_at).
    task automatic run_program(input int ni, input int nit, input logic [63:0] stall_mask,
                               input int stall_pct, input logic [63:0] start_mask,
                               input int reset_at);
        int            n_eff;
        int            n;
        int            exp_done;
        int            nstall;
        int            reads;
        bit            seen_done;
        bit            s;
        logic [AL-1:0] addr_q[$];
        logic [IL-1:0] word_q[$];
        bit            prev_act;
        bit            prev_stall;
        logic [IL-1:0] prev_word;
        logic          prev_v;
        logic [AL-1:0] prev_addr;
        logic [31:0]   tmp;

        n_eff = (nit == 0) ? 1 : nit;
        n     = ni * n_eff;
        for (int it = 0; it < n_eff; it++) begin
            for (int i = 0; i < ni; i++) begin
                tmp = i;
                addr_q.push_back(tmp[AL-1:0]);
                word_q.push_back(mem[i]);
            end
        end
        nstall    = 0;
        reads     = 0;
        seen_done = 0;
        prev_act  = 0;
        prev_stall = 0;
        prev_word = '0;
        prev_v    = 1'b0;
        prev_addr = '0;

        @(posedge clk);
        #1;
        tmp         = ni;
        bus.numInst = tmp[AL-1:0];
        tmp         = nit;
        bus.numIter = tmp[TL-1:0];
        bus.start   = 1'b1;
        bus.stall   = ($urandom_range(0, 1) == 1); // no effect in IDLE
        @(posedge clk);
        #1;
        bus.start = 1'b0;

        for (int k = 1; k < 600; k++) begin
            s = ((k < 64) && stall_mask[k]) || ($urandom_range(0, 99) < stall_pct);
            bus.stall = s;
            bus.start = (k < 64) ? start_mask[k] : 1'b0;
            exp_done  = (ni == 0) ? 1 : 3 + n + nstall;

            if (k == reset_at) begin
                reset = 1'b1;
                #1;
                total++;
                if ({bus.inst_rd_en, bus.inst_rd_addr, bus.instword, bus.instword_v,
                     bus.busy, bus.done} !== '0) begin
                    bad++;
                    $display("FAIL async_reset_outputs: got en=%0b addr=%0h word=%0h v=%0b busy=%0b done=%0b want all 0",
                             bus.inst_rd_en, bus.inst_rd_addr, bus.instword, bus.instword_v,
                             bus.busy, bus.done);
                end
                reset     = 1'b0;
                bus.stall = 1'b0;
                bus.start = 1'b0;
                return;
            end

            @(negedge clk);

            total++;
            if (bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_in_run: cycle %0d got %0b want 1", k, bus.busy);
            end

            if (prev_act && prev_stall) begin
                total++;
                if ({bus.instword, bus.instword_v, bus.inst_rd_addr} !==
                    {prev_word, prev_v, prev_addr}) begin
                    bad++;
                    $display("FAIL stall_hold: cycle %0d got word=%0h v=%0b addr=%0h want word=%0h v=%0b addr=%0h",
                             k, bus.instword, bus.instword_v, bus.inst_rd_addr,
                             prev_word, prev_v, prev_addr);
                end
            end

            if (s) begin
                total++;
                if (bus.inst_rd_en !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_en_in_stall: cycle %0d got %0b want 0", k, bus.inst_rd_en);
                end
            end

            if (bus.inst_rd_en === 1'b1) begin
                reads++;
                total++;
                if (addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_read: cycle %0d got addr %0h want no read",
                             k, bus.inst_rd_addr);
                end else begin
                    if (bus.inst_rd_addr !== addr_q[0]) begin
                        bad++;
                        $display("FAIL read_addr: cycle %0d got %0h want %0h",
                                 k, bus.inst_rd_addr, addr_q[0]);
                    end
                    void'(addr_q.pop_front());
                end
            end

            if (bus.instword_v === 1'b1 && !s) begin
                total++;
                if (word_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: cycle %0d got %0h want none", k, bus.instword);
                end else begin
                    if (bus.instword !== word_q[0]) begin
                        bad++;
                        $display("FAIL word: cycle %0d got %0h want %0h",
                                 k, bus.instword, word_q[0]);
                    end
                    void'(word_q.pop_front());
                end
            end

            total++;
            if (bus.done !== (k == exp_done)) begin
                bad++;
                $display("FAIL done_timing: cycle %0d got done=%0b want done at cycle %0d",
                         k, bus.done, exp_done);
                break;
            end
            if (bus.done === 1'b1) begin
                seen_done = 1;
                total++;
                if (word_q.size() != 0 || addr_q.size() != 0 || reads != ((ni == 0) ? 0 : n)) begin
                    bad++;
                    $display("FAIL completion: got words_left=%0d addrs_left=%0d reads=%0d want 0 0 %0d",
                             word_q.size(), addr_q.size(), reads, (ni == 0) ? 0 : n);
                end
                break;
            end
            if (s) nstall++;

            prev_act   = 1;
            prev_stall = s;
            prev_word  = bus.instword;
            prev_v     = bus.instword_v;
            prev_addr  = bus.inst_rd_addr;

            @(posedge clk);
            #1;
        end

        if (!seen_done) begin
            total++;
            bad++;
            $display("FAIL no_done: got no done pulse want done at cycle %0d", exp_done);
        end

        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            bus.stall = 1'b0;
            bus.start = 1'b0;
            @(negedge clk);
            total++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.inst_rd_en !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_done: got busy=%0b done=%0b rd_en=%0b want 0 0 0",
                         bus.busy, bus.done, bus.inst_rd_en);
            end
        end
    endtask

    task automatic fill_random();
        logic [63:0] tmp;
        for (int i = 0; i < 256; i++) begin
            tmp    = {$urandom, $urandom};
            mem[i] = tmp[IL-1:0];
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.stall   = 1'b0;
        bus.numInst = '0;
        bus.numIter = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.inst_rd_en, bus.inst_rd_addr, bus.instword, bus.instword_v,
             bus.busy, bus.done} !== '0) begin
            bad++;
            $display("FAIL reset_values: got en=%0b addr=%0h word=%0h v=%0b busy=%0b done=%0b want all 0",
                     bus.inst_rd_en, bus.inst_rd_addr, bus.instword, bus.instword_v,
                     bus.busy, bus.done);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%0b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) mem[i] = IL'(32'h100 + i);
        run_program(4, 1, 64'h0, 0, 64'h0, 0);
    endtask

    task automatic test_iterations();
        fill_random();
        run_program(3, 3, 64'h0, 0, 64'h0, 0);
    endtask

    task automatic test_back_pressure();
        fill_random();
        // Stall on the first fetch cycle and for two cycles while word 1 is presented.
        run_program(4, 1, 64'h62, 0, 64'h0, 0);
        run_program(3, 2, 64'h62, 0, 64'h0, 0);
    endtask

    task automatic test_edge_counts();
        fill_random();
        run_program(0, 1, 64'h0, 0, 64'h0, 0);
        run_program(2, 0, 64'h0, 0, 64'h0, 0);
        run_program(1, 2, 64'h0, 0, 64'h0, 0);
    endtask

    task automatic test_reset_mid_run();
        fill_random();
        // Iteration 2, word 1 is presented at cycle 3 + 7.
        run_program(3, 3, 64'h0, 0, 64'h0, 10);
        run_program(3, 3, 64'h0, 0, 64'h0, 0);
    endtask

    task automatic test_start_while_busy();
        fill_random();
        // Start pulses in RUN (cycles 2, 4) and in the DONE cycle (7).
        run_program(4, 1, 64'h0, 0, 64'h94, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_program($urandom_range(1, 12), $urandom_range(0, 4), 64'h0, 30, 64'h0, 0);
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        bus.inst_rd_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_iterations();
        test_back_pressure();
        test_edge_counts();
        test_reset_mid_run();
        test_start_while_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
